// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage.
//   - ALU function codes (funct3 encoding) and the opcode values this stage decodes.
//   - dec_op_t: the decoded operation handed from the decoder to the output register.
//   - Immediate-extraction helpers shared by the decoder.
package alu_pkg;

  localparam int XLEN_DEF = 32;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SLL  = 3'b001;
  localparam logic [2:0] ALU_SLT  = 3'b010;
  localparam logic [2:0] ALU_SLTU = 3'b011;
  localparam logic [2:0] ALU_XOR  = 3'b100;
  localparam logic [2:0] ALU_SR   = 3'b101;
  localparam logic [2:0] ALU_OR   = 3'b110;
  localparam logic [2:0] ALU_AND  = 3'b111;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;

  // funct7 values: base encoding and the alternate (SUB/SRA) encoding.
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  func;
    logic        control;
    logic [4:0]  rd;
    logic        illegal;
  } dec_op_t;

  // Sign-extended I-type immediate.
  function automatic logic [31:0] imm_i(input logic [31:0] instr);
    return {{20{instr[31]}}, instr[31:20]};
  endfunction

  // U-type immediate (upper 20 bits, low 12 bits zero).
  function automatic logic [31:0] imm_u(input logic [31:0] instr);
    return {instr[31:12], 12'h000};
  endfunction

  // Zero-extended shift amount for SLLI/SRLI/SRAI.
  function automatic logic [31:0] imm_shamt(input logic [31:0] instr);
    return {27'd0, instr[24:20]};
  endfunction

endpackage

// File: rtl/alu_decode.sv
// Combinational RV32I decoder for OP, OP-IMM, LUI and AUIPC.
// Ports:
//   instr    in   32  instruction word
//   rs1_data in   32  rs1 register value
//   rs2_data in   32  rs2 register value
//   pc       in   32  instruction address (AUIPC operand A)
//   dec      out  dec_op_t  operands, ALU func/control, rd and illegal flag
module alu_decode
  import alu_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic [31:0] pc,
  output dec_op_t     dec
);

  logic [6:0] opcode_s;
  logic [2:0] funct3_s;
  logic [6:0] funct7_s;
  logic       unused_rs1_idx_s;

  assign opcode_s = instr[6:0];
  assign funct3_s = instr[14:12];
  assign funct7_s = instr[31:25];
  // Register indices are resolved upstream; only the data arrives here.
  assign unused_rs1_idx_s = ^instr[19:15];

  // Opcode decode into operands and ALU function/control.
  always_comb begin
    dec         = '0;
    dec.rd      = instr[11:7];
    dec.illegal = 1'b0;
    case (opcode_s)
      OPC_OP: begin
        dec.a       = rs1_data;
        dec.b       = rs2_data;
        dec.func    = funct3_s;
        dec.control = instr[30];
        // The alternate funct7 only exists for SUB and SRA.
        if (funct7_s == F7_BASE) begin
          dec.illegal = 1'b0;
        end else if ((funct7_s == F7_ALT) &&
                     ((funct3_s == ALU_ADD) || (funct3_s == ALU_SR))) begin
          dec.illegal = 1'b0;
        end else begin
          dec.illegal = 1'b1;
        end
      end
      OPC_OPIMM: begin
        dec.a    = rs1_data;
        dec.func = funct3_s;
        case (funct3_s)
          ALU_SLL: begin
            dec.b       = imm_shamt(instr);
            dec.control = 1'b0;
            dec.illegal = (funct7_s != F7_BASE);
          end
          ALU_SR: begin
            dec.b       = imm_shamt(instr);
            dec.control = instr[30];
            dec.illegal = (funct7_s != F7_BASE) && (funct7_s != F7_ALT);
          end
          default: begin
            dec.b       = imm_i(instr);
            dec.control = 1'b0;
            dec.illegal = 1'b0;
          end
        endcase
      end
      OPC_LUI: begin
        dec.a    = 32'd0;
        dec.b    = imm_u(instr);
        dec.func = ALU_ADD;
      end
      OPC_AUIPC: begin
        dec.a    = pc;
        dec.b    = imm_u(instr);
        dec.func = ALU_ADD;
      end
      default: begin
        // Undecodable: zero payload, still carries rd and flows through.
        dec.illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/alu_issue.sv
// ALU issue stage: decodes one instruction per cycle and presents it to the
// execute stage through a registered valid/ready output backed by a skid entry.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   in_valid/in_ready            input handshake
//   in_instr, in_rs1_data,
//   in_rs2_data, in_pc           instruction and its operands
//   out_valid/out_ready          output handshake
//   operand_A, operand_B, func,
//   control, rd, illegal         decoded operation (registered)
// Parameters:
//   XLEN     datapath width (32 only)
//   SKID_EN  1: registered in_ready with skid entry; 0: pass-through in_ready
module alu_issue
  import alu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int SKID_EN = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_rs1_data,
  input  logic [XLEN-1:0] in_rs2_data,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] operand_A,
  output logic [XLEN-1:0] operand_B,
  output logic [2:0]      func,
  output logic            control,
  output logic [4:0]      rd,
  output logic            illegal
);

  dec_op_t dec_s;
  dec_op_t out_r, out_nxt_s;
  dec_op_t skid_r, skid_nxt_s;
  logic    out_valid_r, out_valid_nxt_s;
  logic    skid_valid_r, skid_valid_nxt_s;
  logic    in_ready_r;
  logic    in_ready_s;
  logic    in_xfer_s;
  logic    out_load_s;

  alu_decode u_decode (
    .instr    (in_instr),
    .rs1_data (in_rs1_data),
    .rs2_data (in_rs2_data),
    .pc       (in_pc),
    .dec      (dec_s)
  );

  assign in_ready_s = (SKID_EN != 0) ? in_ready_r : (!out_valid_r || out_ready);
  assign in_xfer_s  = in_valid && in_ready_s;
  // Output register may take a new entry when empty or being consumed.
  assign out_load_s = !out_valid_r || out_ready;

  // Next-state for the output and skid entries; skid always drains first.
  always_comb begin
    out_nxt_s        = out_r;
    out_valid_nxt_s  = out_valid_r;
    skid_nxt_s       = skid_r;
    skid_valid_nxt_s = skid_valid_r;
    if (out_load_s) begin
      if (skid_valid_r) begin
        out_nxt_s       = skid_r;
        out_valid_nxt_s = 1'b1;
        if (in_xfer_s) begin
          skid_nxt_s       = dec_s;
          skid_valid_nxt_s = 1'b1;
        end else begin
          skid_valid_nxt_s = 1'b0;
        end
      end else if (in_xfer_s) begin
        out_nxt_s       = dec_s;
        out_valid_nxt_s = 1'b1;
      end else begin
        out_valid_nxt_s = 1'b0;
      end
    end else begin
      // Output stalled: a transferring input parks in the skid entry.
      if (in_xfer_s) begin
        skid_nxt_s       = dec_s;
        skid_valid_nxt_s = 1'b1;
      end else begin
        skid_valid_nxt_s = skid_valid_r;
      end
    end
  end

  // State registers; reset discards both entries.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_r        <= '0;
      skid_r       <= '0;
      out_valid_r  <= 1'b0;
      skid_valid_r <= 1'b0;
      in_ready_r   <= 1'b1;
    end else begin
      out_r        <= out_nxt_s;
      skid_r       <= skid_nxt_s;
      out_valid_r  <= out_valid_nxt_s;
      skid_valid_r <= skid_valid_nxt_s;
      in_ready_r   <= !skid_valid_nxt_s;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_r;
  assign operand_A = out_r.a;
  assign operand_B = out_r.b;
  assign func      = out_r.func;
  assign control   = out_r.control;
  assign rd        = out_r.rd;
  assign illegal   = out_r.illegal;

endmodule
